// File: rtl/aurora_rx_data_controller_if.sv
// Framing types shared by the lane receive path, plus the bundle that
// carries lane-side ordered-set/data inputs and the AXI-Stream-style outputs.
package aurora_pkg;

   localparam int AXI_DATA_SIZE = 32;

   // Per-cycle framing code from the lane decoder. The field is three bits
   // wide, so encodings 4..7 exist on the wire and are handled as idles.
   typedef enum logic [2:0] {
      NONE = 3'd0,
      SCP  = 3'd1,
      ECP  = 3'd2,
      I    = 3'd3
   } ordered_sets_e;

endpackage

// Lane-side inputs and user-side outputs of the receive data controller.
// The master side is whatever feeds ordered sets (decoder or bench); the
// slave side is the controller itself.
interface aurora_rx_data_controller_if #(
   parameter int LEN_W = 16
);

   aurora_pkg::ordered_sets_e                   ordered_sets;
   logic [aurora_pkg::AXI_DATA_SIZE-1:0]        data_in;
   logic                                        axi_valid;
   logic                                        axi_last;
   logic [aurora_pkg::AXI_DATA_SIZE-1:0]        axi_data;
   logic [LEN_W-1:0]                            frame_beats;
   logic                                        err_scp_in_frame;
   logic                                        err_ecp_no_frame;
   logic                                        err_empty_frame;

   modport master (
      output ordered_sets,
      output data_in,
      input  axi_valid,
      input  axi_last,
      input  axi_data,
      input  frame_beats,
      input  err_scp_in_frame,
      input  err_ecp_no_frame,
      input  err_empty_frame
   );

   modport slave (
      input  ordered_sets,
      input  data_in,
      output axi_valid,
      output axi_last,
      output axi_data,
      output frame_beats,
      output err_scp_in_frame,
      output err_ecp_no_frame,
      output err_empty_frame
   );

endinterface

// File: rtl/aurora_rx_data_controller.sv
// Receive data controller: rebuilds AXI-Stream-style beats with valid/last
// from the lane ordered-set stream. One data beat is always held back so
// the final beat of a frame can be tagged last when ECP arrives.
module aurora_rx_data_controller #(
   parameter int LEN_W = 16
) (
   input  logic                          clk_data,
   input  logic                          rst,
   aurora_rx_data_controller_if.slave    rxIf
);

   import aurora_pkg::*;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OPEN = 2'd1,
      HOLD = 2'd2
   } state_e;

   localparam logic [LEN_W-1:0] CNT_MAX = {LEN_W{1'b1}};
   localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

   state_e                      state_q,          state_d;
   logic [AXI_DATA_SIZE-1:0]    holdData_q,       holdData_d;
   logic [LEN_W-1:0]            beatCnt_q,        beatCnt_d;
   logic                        axiValid_q,       axiValid_d;
   logic                        axiLast_q,        axiLast_d;
   logic [AXI_DATA_SIZE-1:0]    axiData_q,        axiData_d;
   logic [LEN_W-1:0]            frameBeats_q,     frameBeats_d;
   logic                        errScpInFrame_q,  errScpInFrame_d;
   logic                        errEcpNoFrame_q,  errEcpNoFrame_d;
   logic                        errEmptyFrame_q,  errEmptyFrame_d;

   ordered_sets_e               osCode;
   logic [LEN_W-1:0]            beatCntInc;

   // Collapse any encoding outside the four legal codes onto idle, so the
   // FSM below only ever has to reason about NONE/SCP/ECP/I.
   always_comb begin
      osCode = I;
      case (rxIf.ordered_sets)
         NONE:    osCode = NONE;
         SCP:     osCode = SCP;
         ECP:     osCode = ECP;
         default: osCode = I;
      endcase
   end

   // Beat counter increment that sticks at all-ones instead of wrapping;
   // an over-long frame is still delivered, only its length is clipped.
   always_comb begin
      beatCntInc = (beatCnt_q == CNT_MAX) ? beatCnt_q : beatCnt_q + CNT_ONE;
   end

   // Next-state and next-output decode. Every output defaults to zero so
   // each pulse lasts exactly one cycle; an idle code anywhere leaves the
   // state, held beat and counter untouched.
   always_comb begin
      state_d         = state_q;
      holdData_d      = holdData_q;
      beatCnt_d       = beatCnt_q;
      axiValid_d      = 1'b0;
      axiLast_d       = 1'b0;
      axiData_d       = '0;
      frameBeats_d    = '0;
      errScpInFrame_d = 1'b0;
      errEcpNoFrame_d = 1'b0;
      errEmptyFrame_d = 1'b0;

      case (state_q)
         IDLE: begin
            case (osCode)
               SCP: begin
                  state_d   = OPEN;
                  beatCnt_d = '0;
               end
               ECP:     errEcpNoFrame_d = 1'b1;
               default: ;
            endcase
         end

         OPEN: begin
            case (osCode)
               NONE: begin
                  holdData_d = rxIf.data_in;
                  beatCnt_d  = CNT_ONE;
                  state_d    = HOLD;
               end
               ECP: begin
                  errEmptyFrame_d = 1'b1;
                  state_d         = IDLE;
               end
               SCP: begin
                  errScpInFrame_d = 1'b1;
                  beatCnt_d       = '0;
               end
               default: ;
            endcase
         end

         HOLD: begin
            case (osCode)
               NONE: begin
                  axiValid_d = 1'b1;
                  axiData_d  = holdData_q;
                  holdData_d = rxIf.data_in;
                  beatCnt_d  = beatCntInc;
               end
               ECP: begin
                  axiValid_d   = 1'b1;
                  axiLast_d    = 1'b1;
                  axiData_d    = holdData_q;
                  frameBeats_d = beatCnt_q;
                  holdData_d   = '0;
                  state_d      = IDLE;
               end
               SCP: begin
                  errScpInFrame_d = 1'b1;
                  holdData_d      = '0;
                  beatCnt_d       = '0;
                  state_d         = OPEN;
               end
               default: ;
            endcase
         end

         default: state_d = IDLE;
      endcase
   end

   // State, held beat, counter and all registered outputs; reset discards
   // any held beat silently and forces every output low.
   always_ff @(posedge clk_data) begin
      if (rst) begin
         state_q         <= IDLE;
         holdData_q      <= '0;
         beatCnt_q       <= '0;
         axiValid_q      <= 1'b0;
         axiLast_q       <= 1'b0;
         axiData_q       <= '0;
         frameBeats_q    <= '0;
         errScpInFrame_q <= 1'b0;
         errEcpNoFrame_q <= 1'b0;
         errEmptyFrame_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         holdData_q      <= holdData_d;
         beatCnt_q       <= beatCnt_d;
         axiValid_q      <= axiValid_d;
         axiLast_q       <= axiLast_d;
         axiData_q       <= axiData_d;
         frameBeats_q    <= frameBeats_d;
         errScpInFrame_q <= errScpInFrame_d;
         errEcpNoFrame_q <= errEcpNoFrame_d;
         errEmptyFrame_q <= errEmptyFrame_d;
      end
   end

   assign rxIf.axi_valid        = axiValid_q;
   assign rxIf.axi_last         = axiLast_q;
   assign rxIf.axi_data         = axiData_q;
   assign rxIf.frame_beats      = frameBeats_q;
   assign rxIf.err_scp_in_frame = errScpInFrame_q;
   assign rxIf.err_ecp_no_frame = errEcpNoFrame_q;
   assign rxIf.err_empty_frame  = errEmptyFrame_q;

endmodule

// File: tb/tb_aurora_rx_data_controller.sv
// Bench for the receive data controller: two instances (16-bit and 2-bit
// length counters) see identical stimulus; a frame-level queue model
// predicts every output cycle.
module tb_aurora_rx_data_controller;

   import aurora_pkg::*;

   logic clock = 1'b0;
   logic rst   = 1'b1;

   int compared   = 0;
   int mismatched = 0;

   aurora_rx_data_controller_if #(.LEN_W(16)) ifWide ();
   aurora_rx_data_controller_if #(.LEN_W(2))  ifNarrow ();

   aurora_rx_data_controller #(.LEN_W(16)) dutWide (
      .clk_data (clock),
      .rst      (rst),
      .rxIf     (ifWide.slave)
   );

   aurora_rx_data_controller #(.LEN_W(2)) dutNarrow (
      .clk_data (clock),
      .rst      (rst),
      .rxIf     (ifNarrow.slave)
   );

   // Free-running data clock.
   always #5 clock = ~clock;

   // Reference model: whether a frame is open, and every data word seen in
   // the current frame. A word is released when the next one (or ECP)
   // arrives, so the most recent word is the one still awaiting output.
   bit                        mInFrame = 1'b0;
   logic [AXI_DATA_SIZE-1:0]  mFrame[$];

   logic                      eValid, eLast, eScp, eEcp, eEmpty;
   logic [AXI_DATA_SIZE-1:0]  eData;
   int                        eBeatsWide, eBeatsNarrow;

   function automatic int clipLen(int n, int maxVal);
      return (n > maxVal) ? maxVal : n;
   endfunction

   // Advance the model by one input cycle and produce the expected outputs.
   task automatic modelStep(input logic rstIn, input ordered_sets_e os,
                            input logic [AXI_DATA_SIZE-1:0] d);
      eValid = 0; eLast = 0; eScp = 0; eEcp = 0; eEmpty = 0;
      eData = '0; eBeatsWide = 0; eBeatsNarrow = 0;
      if (rstIn) begin
         mInFrame = 1'b0;
         mFrame.delete();
      end else if (os == SCP) begin
         if (mInFrame) eScp = 1;
         mFrame.delete();
         mInFrame = 1'b1;
      end else if (os == ECP) begin
         if (!mInFrame) eEcp = 1;
         else if (mFrame.size() == 0) eEmpty = 1;
         else begin
            eValid       = 1;
            eLast        = 1;
            eData        = mFrame[$];
            eBeatsWide   = clipLen(mFrame.size(), 65535);
            eBeatsNarrow = clipLen(mFrame.size(), 3);
         end
         mInFrame = 1'b0;
         mFrame.delete();
      end else if (os == NONE) begin
         if (mInFrame) begin
            if (mFrame.size() > 0) begin
               eValid = 1;
               eData  = mFrame[$];
            end
            mFrame.push_back(d);
         end
      end
   endtask

   task automatic checkValue(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t",
                tag, observed, expected, $time);
      end
   endtask

   // Compare both instances against the model's expectation for this cycle.
   task automatic checkOutput(input string stepName);
      checkValue({stepName, " valid"},    32'(ifWide.axi_valid),        32'(eValid));
      checkValue({stepName, " last"},     32'(ifWide.axi_last),         32'(eLast));
      checkValue({stepName, " data"},     ifWide.axi_data,              eData);
      checkValue({stepName, " beats16"},  32'(ifWide.frame_beats),      32'(eBeatsWide));
      checkValue({stepName, " errScp"},   32'(ifWide.err_scp_in_frame), 32'(eScp));
      checkValue({stepName, " errEcp"},   32'(ifWide.err_ecp_no_frame), 32'(eEcp));
      checkValue({stepName, " errEmpty"}, 32'(ifWide.err_empty_frame),  32'(eEmpty));
      checkValue({stepName, " n.valid"},  32'(ifNarrow.axi_valid),      32'(eValid));
      checkValue({stepName, " n.last"},   32'(ifNarrow.axi_last),       32'(eLast));
      checkValue({stepName, " n.data"},   ifNarrow.axi_data,            eData);
      checkValue({stepName, " beats2"},   32'(ifNarrow.frame_beats),    32'(eBeatsNarrow));
      checkValue({stepName, " n.errs"},
                 32'({ifNarrow.err_scp_in_frame, ifNarrow.err_ecp_no_frame,
                      ifNarrow.err_empty_frame}),
                 32'({eScp, eEcp, eEmpty}));
   endtask

   // Drive one input cycle on both instances, then check the registered
   // response just after the edge that samples it.
   task automatic applyStimulus(input string stepName, input logic rstIn,
                                input ordered_sets_e os,
                                input logic [AXI_DATA_SIZE-1:0] d);
      @(negedge clock);
      rst                   = rstIn;
      ifWide.ordered_sets   = os;
      ifWide.data_in        = d;
      ifNarrow.ordered_sets = os;
      ifNarrow.data_in      = d;
      modelStep(rstIn, os, d);
      @(posedge clock);
      #1;
      checkOutput(stepName);
   endtask

   initial begin
      ordered_sets_e rOs;
      int            pick;
      ifWide.ordered_sets   = I;
      ifWide.data_in        = '0;
      ifNarrow.ordered_sets = I;
      ifNarrow.data_in      = '0;

      // Reset state.
      applyStimulus("reset0", 1'b1, NONE, 32'h1234);
      applyStimulus("reset1", 1'b1, ECP,  32'h0);

      // Basic three-beat frame.
      applyStimulus("basic scp",  1'b0, SCP,  32'h0);
      applyStimulus("basic d1",   1'b0, NONE, 32'd1);
      applyStimulus("basic d2",   1'b0, NONE, 32'd2);
      applyStimulus("basic d3",   1'b0, NONE, 32'd3);
      applyStimulus("basic ecp",  1'b0, ECP,  32'h0);
      applyStimulus("basic idle", 1'b0, I,    32'hFFFF);

      // Idle insertion inside a frame, including an illegal encoding.
      applyStimulus("idle scp", 1'b0, SCP,  32'h0);
      applyStimulus("idle dA",  1'b0, NONE, 32'hA);
      applyStimulus("idle i1",  1'b0, I,    32'h55);
      applyStimulus("idle i2",  1'b0, ordered_sets_e'(3'd6), 32'h66);
      applyStimulus("idle dB",  1'b0, NONE, 32'hB);
      applyStimulus("idle i3",  1'b0, I,    32'h77);
      applyStimulus("idle ecp", 1'b0, ECP,  32'h0);

      // Single-beat frame followed by a back-to-back SCP.
      applyStimulus("single scp",  1'b0, SCP,  32'h0);
      applyStimulus("single d5",   1'b0, NONE, 32'h5);
      applyStimulus("single ecp",  1'b0, ECP,  32'h0);
      applyStimulus("b2b scp",     1'b0, SCP,  32'h0);
      applyStimulus("b2b dC",      1'b0, NONE, 32'hC);
      applyStimulus("b2b ecp",     1'b0, ECP,  32'h0);

      // Framing errors.
      applyStimulus("err ecpIdle", 1'b0, ECP,  32'h0);
      applyStimulus("err noneIdl", 1'b0, NONE, 32'hDEAD);
      applyStimulus("err scp",     1'b0, SCP,  32'h0);
      applyStimulus("err empty",   1'b0, ECP,  32'h0);
      applyStimulus("err scp2",    1'b0, SCP,  32'h0);
      applyStimulus("err scpOpen", 1'b0, SCP,  32'h0);
      applyStimulus("err d7",      1'b0, NONE, 32'h7);
      applyStimulus("err scpHold", 1'b0, SCP,  32'h0);
      applyStimulus("err d8",      1'b0, NONE, 32'h8);
      applyStimulus("err ecp8",    1'b0, ECP,  32'h0);

      // Five-beat frame: the 2-bit counter saturates at 3.
      applyStimulus("sat scp", 1'b0, SCP, 32'h0);
      for (int k = 1; k <= 5; k++)
         applyStimulus($sformatf("sat d%0d", k), 1'b0, NONE, 32'h100 + 32'(k));
      applyStimulus("sat ecp", 1'b0, ECP, 32'h0);

      // Reset in the middle of a frame drops the held beat silently.
      applyStimulus("rst scp", 1'b0, SCP,  32'h0);
      applyStimulus("rst d9",  1'b0, NONE, 32'h9);
      applyStimulus("rst mid", 1'b1, NONE, 32'h99);
      applyStimulus("rst ecp", 1'b0, ECP,  32'h0);
      applyStimulus("rst i",   1'b0, I,    32'h0);

      // Randomized traffic weighted toward data beats.
      for (int n = 0; n < 600; n++) begin
         pick = int'($urandom_range(0, 99));
         if      (pick < 50) rOs = NONE;
         else if (pick < 65) rOs = I;
         else if (pick < 78) rOs = SCP;
         else if (pick < 91) rOs = ECP;
         else                rOs = ordered_sets_e'(3'($urandom_range(4, 7)));
         applyStimulus($sformatf("rand%0d", n), ($urandom_range(0, 99) < 2),
                       rOs, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
